// File: rtl/fifo_to_mem_wr_ctrl.sv
// fifo_to_mem_wr_ctrl
// Drains a fixed-length burst of words from a sync FIFO and issues each word
// as a single memory write request. Each request gets its own address, which
// steps by ADDR_STEP. A one-cycle done pulse closes the burst.
//
// Handshake: mem_req is a valid. It stays high, and mem_addr/mem_wdata stay
// frozen, until a cycle in which mem_req and mem_ack are both high. That
// cycle is the transfer. mem_ack is ignored in every other cycle.
module fifo_to_mem_wr_ctrl #(
   parameter int DATA_WIDTH  = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int ADDR_STEP   = 32,
   parameter int OUTPUT_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   output logic [LEN_WIDTH-1:0]  words_done
);

   // In registered-output mode, read data appears one cycle after the pop.
   localparam bit REG_DOUT = (OUTPUT_MODE != 0);
   localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(ADDR_STEP);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT_RD = 3'd2,
      S_REQ     = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] words_next;
   logic                 start_ok;
   logic                 pop;
   logic                 ack_hit;

   assign words_next = words_done + LEN_ONE;
   assign start_ok   = (state_q == S_IDLE) && start && (burst_len != '0);
   assign pop        = (state_q == S_FETCH) && !fifo_empty;
   assign ack_hit    = (state_q == S_REQ) && mem_ack;

   // State register; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the strobes decoded from the current state.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      fifo_rd = 1'b0;
      mem_req = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (burst_len != '0) ? S_FETCH : S_DONE;
            end
         end
         S_FETCH: begin
            busy    = 1'b1;
            fifo_rd = !fifo_empty;
            if (!fifo_empty) begin
               state_d = REG_DOUT ? S_WAIT_RD : S_REQ;
            end
         end
         S_WAIT_RD: begin
            busy    = 1'b1;
            state_d = S_REQ;
         end
         S_REQ: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_ack) begin
               state_d = (words_next == len_q) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Burst parameters, address walk, and acknowledged-word count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q      <= '0;
         mem_addr   <= '0;
         words_done <= '0;
      end else if (start_ok) begin
         len_q      <= burst_len;
         mem_addr   <= base_addr;
         words_done <= '0;
      end else if (ack_hit) begin
         mem_addr   <= mem_addr + STEP;
         words_done <= words_next;
      end
   end

   // Write-data capture: in the pop cycle (comb FIFO) or one cycle later (registered FIFO).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_wdata <= '0;
      end else if (!REG_DOUT && pop) begin
         mem_wdata <= fifo_dout;
      end else if (REG_DOUT && (state_q == S_WAIT_RD)) begin
         mem_wdata <= fifo_dout;
      end
   end

endmodule
